// File: rtl/adc_level_meter.sv
// Front-panel ADC level meter: peak-hold bar graph with timed linear decay and overload LED.
// Optional macro ADC_METER_OTR_STRETCH_EN stretches each overload to OTR_HOLD clocks.
module adc_level_meter #(
  parameter int unsigned ADC_WIDTH    = 12,
  parameter int unsigned LEDS         = 4,
  parameter int unsigned DECAY_PERIOD = 65536,
  parameter int unsigned DECAY_STEP   = 16,
  parameter int unsigned OTR_HOLD     = 4000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_WIDTH-1:0] ADC_Data,
  input  logic                 ADC_OTR,
  output logic [LEDS-1:0]      leds,
  output logic                 ovl,
  output logic [ADC_WIDTH-2:0] peak
);

  localparam int unsigned MagW = ADC_WIDTH - 1;
  localparam int unsigned TmrW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(DECAY_PERIOD - 1);
  localparam logic [ADC_WIDTH-1:0] MostNeg = {1'b1, {MagW{1'b0}}};
  // A step wider than the peak register always decays straight to zero.
  localparam bit StepBig = 64'(DECAY_STEP) >= (64'd1 << MagW);
  localparam logic [MagW-1:0] StepV = MagW'(DECAY_STEP);

  if (LEDS < 1 || LEDS > ADC_WIDTH - 1) begin : g_bad_leds
    $error("LEDS must lie in 1..ADC_WIDTH-1");
  end
  if (DECAY_PERIOD < 1) begin : g_bad_period
    $error("DECAY_PERIOD must be at least 1");
  end
  if (OTR_HOLD < 1) begin : g_bad_hold
    $error("OTR_HOLD must be at least 1");
  end

  // S1: input register
  logic [ADC_WIDTH-1:0] data_q;
  logic                 otr1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      otr1_q <= 1'b0;
    end else begin
      data_q <= ADC_Data;
      otr1_q <= ADC_OTR;
    end
  end

  // S2: magnitude, most-negative code saturates instead of wrapping
  logic [MagW-1:0] mag_d, mag_q;
  logic            otr2_q;

  always_comb begin
    mag_d = data_q[MagW-1:0];
    if (data_q[ADC_WIDTH-1]) begin
      if (data_q == MostNeg) begin
        mag_d = '1;
      end else begin
        mag_d = ~data_q[MagW-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q  <= '0;
      otr2_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      otr2_q <= otr2_d_fwd(otr1_q);
    end
  end

  function automatic logic otr2_d_fwd(input logic otr);
    return otr;
  endfunction

  // S3: peak hold with decay timer; a new maximum beats a same-cycle tick
  logic [MagW-1:0] peak_d, peak_q;
  logic [TmrW-1:0] tmr_d, tmr_q;
  logic            tick;
  logic            otr3_q;

  always_comb begin
    tick   = (tmr_q == TmrLast);
    peak_d = peak_q;
    tmr_d  = tick ? '0 : tmr_q + 1'b1;
    if (mag_q > peak_q) begin
      peak_d = mag_q;
      tmr_d  = '0;
    end else if (tick) begin
      if (!StepBig && (peak_q > StepV)) begin
        peak_d = peak_q - StepV;
      end else begin
        peak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
      tmr_q  <= '0;
      otr3_q <= 1'b0;
    end else begin
      peak_q <= peak_d;
      tmr_q  <= tmr_d;
      otr3_q <= otr2_q;
    end
  end

  // S4: thermometer bar graph and overload indicator
  logic [LEDS-1:0] leds_d, leds_q;
  logic            ovl_d, ovl_q;

  always_comb begin
    leds_d = '0;
    for (int unsigned k = 0; k < LEDS; k++) begin
      leds_d[k] = (peak_q >> (MagW - LEDS + k)) != '0;
    end
  end

`ifdef ADC_METER_OTR_STRETCH_EN
  localparam int unsigned CntW = (OTR_HOLD > 1) ? $clog2(OTR_HOLD) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(OTR_HOLD - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (otr3_q) begin
      cnt_d = HoldLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    ovl_d = otr3_q | (cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    ovl_d = otr3_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
      ovl_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      ovl_q  <= ovl_d;
    end
  end

  assign leds = leds_q;
  assign ovl  = ovl_q;
  assign peak = peak_q;

endmodule
